tl_phase_ctrl: RTL



---
 rtl/tl_pkg.sv | 41 ++++
 rtl/tl_tick_gen.sv | 18 +
 rtl/tl_phase_ctrl.sv | 74 +++++++
 3 files changed

// File: rtl/tl_pkg.sv
// tl_pkg: state codes, lamp bit positions and light patterns for tl_phase_ctrl.
package tl_pkg;

    typedef enum logic [2:0] {
        GA = 3'd0,
        YA = 3'd1,
        RA = 3'd2,
        GB = 3'd3,
        YB = 3'd4,
        RB = 3'd5,
        PW = 3'd6
    } state_t;

    localparam int G1 = 5;
    localparam int Y1 = 4;
    localparam int R1 = 3;
    localparam int G2 = 2;
    localparam int Y2 = 1;
    localparam int R2 = 0;

    localparam logic [5:0] LIGHT_GA = 6'b100001;
    localparam logic [5:0] LIGHT_YA = 6'b010001;
    localparam logic [5:0] LIGHT_RA = 6'b001001;
    localparam logic [5:0] LIGHT_GB = 6'b001100;
    localparam logic [5:0] LIGHT_YB = 6'b001010;
    localparam logic [5:0] LIGHT_RB = 6'b001001;
    localparam logic [5:0] LIGHT_PW = 6'b001001;

    function automatic logic [5:0] light_of(state_t s);
        case (s)
            YA:      return LIGHT_YA;
            RA:      return LIGHT_RA;
            GB:      return LIGHT_GB;
            YB:      return LIGHT_YB;
            RB:      return LIGHT_RB;
            PW:      return LIGHT_PW;
            default: return LIGHT_GA;
        endcase
    endfunction

endpackage

// File: rtl/tl_tick_gen.sv
// tl_tick_gen: free-running prescaler giving a one-clk tick every CLK_DIV clocks.
module tl_tick_gen #(
    parameter int CLK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;

    logic [W-1:0] div;

    assign tick = div == W'(CLK_DIV - 1);

    always_ff @(posedge clk or negedge reset)
        if (!reset) div <= '0;
        else        div <= tick ? '0 : div + 1'b1;
endmodule

// File: rtl/tl_phase_ctrl.sv
// tl_phase_ctrl: two-road phase scheduler with yellow, all-red and pedestrian walk phases.
// All transitions are taken on prescaler ticks; lamps are registered from the next state.
module tl_phase_ctrl
    import tl_pkg::*;
#(
    parameter int CLK_DIV = 50_000_000,
    parameter int MIN_G   = 5,
    parameter int MAX_G   = 30,
    parameter int YEL_T   = 3,
    parameter int RED_T   = 1,
    parameter int WALK_T  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sense_a,
    input  logic       sense_b,
    input  logic       ped_req,
    output logic [5:0] light,
    output logic       walk,
    output logic [2:0] phase
);
    localparam logic [8:0] MIN_E  = 9'(MIN_G);
    localparam logic [8:0] MAX_E  = 9'(MAX_G);
    localparam logic [8:0] YEL_E  = 9'(YEL_T);
    localparam logic [8:0] RED_E  = 9'(RED_T);
    localparam logic [8:0] WALK_E = 9'(WALK_T);

    state_t     state, nxt;
    logic [7:0] cnt;
    logic [8:0] e;
    logic       tick, ped_pend, next_b, enter_pw;

    tl_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // e counts the current tick, so it can reach 256 once cnt has saturated
    assign e        = {1'b0, cnt} + 9'd1;
    assign enter_pw = nxt == PW && state != PW;
    assign phase    = state;

    always_comb begin
        nxt = state;
        case (state)
            GA: if (tick && e >= MIN_E && (sense_b || ped_pend) && (!sense_a || e >= MAX_E)) nxt = YA;
            GB: if (tick && e >= MIN_E && (sense_a || ped_pend) && (!sense_b || e >= MAX_E)) nxt = YB;
            YA: if (tick && e == YEL_E) nxt = RA;
            YB: if (tick && e == YEL_E) nxt = RB;
            RA: if (tick && e == RED_E) nxt = ped_pend ? PW : GB;
            RB: if (tick && e == RED_E) nxt = ped_pend ? PW : GA;
            PW: if (tick && e == WALK_E) nxt = next_b ? GB : GA;
            default: nxt = GA;
        endcase
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state    <= GA;
            cnt      <= '0;
            ped_pend <= 1'b0;
            next_b   <= 1'b0;
            light    <= LIGHT_GA;
            walk     <= 1'b0;
        end else begin
            state    <= nxt;
            cnt      <= nxt != state ? '0 : (tick && cnt != 8'hff) ? cnt + 1'b1 : cnt;
            ped_pend <= enter_pw ? 1'b0 : (ped_req && state != PW) ? 1'b1 : ped_pend;
            next_b   <= enter_pw ? state == RA : next_b;
            light    <= light_of(nxt);
            walk     <= nxt == PW;
        end
endmodule
